// File: rtl/sincos_pkg.sv
// Shared defaults and FSM encoding for the sin/cos
// phase generator.
package sincos_pkg;

  localparam int DEF_PHASE_W = 47;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_DEC_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sincos_phase_acc.sv
// Phase accumulator: load a start phase, add an
// increment, or hold. Wraps modulo 2^W.
module sincos_phase_acc
  import sincos_pkg::*;
#(
  parameter int W = DEF_PHASE_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         add,
  input  logic [W-1:0] inc,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
    end else if (ld) begin
      acc <= ld_val;
    end else if (add) begin
      acc <= acc + inc;
    end
  end

endmodule

// File: rtl/sincos_phase_gen.sv
// Burst phase generator feeding the sin/cos core:
// emits count samples spaced decim+1 cycles apart.
module sincos_phase_gen
  import sincos_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEC_W   = DEF_DEC_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PHASE_W-1:0] freq_i,
  input  logic               freq_load_i,
  input  logic [PHASE_W-1:0] phase_off_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic [DEC_W-1:0]   decim_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o
);

  state_t state, state_nx;

  logic [PHASE_W-1:0] freq_q;
  logic [CNT_W-1:0]   left_q;
  logic               cont_q;
  logic [DEC_W-1:0]   dec_q;
  logic [DEC_W-1:0]   dcnt_q;

  logic tick, last, ld, add;

  assign tick = (dcnt_q == dec_q);
  // left_q counts samples still owed after the
  // one already on the output
  assign last = !cont_q && (left_q == '0);

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    add      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nx = S_RUN;
          ld       = 1'b1;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_nx = S_IDLE;
        end else if (last) begin
          state_nx = S_DONE;
        end else if (tick) begin
          add = 1'b1;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_nx;
      valid_o <= ld | add;
      busy_o  <= (state_nx == S_RUN);
      done_o  <= (state == S_RUN) && !stop_i
                 && last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      freq_q <= '0;
    end else if (freq_load_i) begin
      freq_q <= freq_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      left_q <= '0;
      cont_q <= 1'b0;
      dec_q  <= '0;
      dcnt_q <= '0;
    end else if (ld) begin
      left_q <= count_i - CNT_W'(1);
      cont_q <= (count_i == '0);
      dec_q  <= decim_i;
      dcnt_q <= '0;
    end else if (state == S_RUN) begin
      if (tick) begin
        dcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_q + DEC_W'(1);
      end
      if (add && !cont_q) begin
        left_q <= left_q - CNT_W'(1);
      end
    end
  end

  sincos_phase_acc #(
    .W (PHASE_W)
  ) u_acc (
    .clk    (clk),
    .resetn (resetn),
    .ld     (ld),
    .ld_val (phase_off_i),
    .add    (add),
    .inc    (freq_q),
    .acc    (phase_o)
  );

endmodule

// File: tb/tb_sincos_phase_gen.sv
// Self-checking bench for sincos_phase_gen: vector
// table, directed corner sequences, random bursts.
module tb_sincos_phase_gen;

  localparam int PW = 47;
  localparam int CW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [PW-1:0] freq_i = '0;
  logic          freq_load_i = 1'b0;
  logic [PW-1:0] phase_off_i = '0;
  logic [CW-1:0] count_i = '0;
  logic [DW-1:0] decim_i = '0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [PW-1:0] phase_o;
  logic          valid_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] ph_m = '0;
  logic [PW-1:0] freq_m = '0;

  sincos_phase_gen #(
    .PHASE_W (PW),
    .CNT_W   (CW),
    .DEC_W   (DW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .freq_i      (freq_i),
    .freq_load_i (freq_load_i),
    .phase_off_i (phase_off_i),
    .count_i     (count_i),
    .decim_i     (decim_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .phase_o     (phase_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] freq;
    logic [PW-1:0] off;
    int            n;
    int            d;
    int            nv;
    logic [PW-1:0] ph [4];
    int            ve [4];
    int            done_e;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rnd_ph();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  task automatic load_freq(input logic [PW-1:0] f);
    freq_i = f;
    freq_load_i = 1'b1;
    tick();
    freq_load_i = 1'b0;
    freq_m = f;
  endtask

  task automatic chk_out(input string nm,
                         input logic v,
                         input logic b,
                         input logic d);
    chk({nm, "_valid"}, 64'(valid_o), 64'(v));
    chk({nm, "_busy"}, 64'(busy_o), 64'(b));
    chk({nm, "_done"}, 64'(done_o), 64'(d));
    chk({nm, "_phase"}, 64'(phase_o), 64'(ph_m));
  endtask

  // Edge e = 0 is the start edge; sample k lands on
  // edge k*(d+1). A freq load seen at an edge only
  // affects samples on later edges.
  task automatic burst(input logic [PW-1:0] off,
                       input int n,
                       input int d,
                       input int stop_at);
    int  lst;
    int  last_e;
    bit  prev_alive;
    lst = (n > 0) ? (n - 1) * (d + 1) : 0;
    last_e = (n == 0) ? stop_at : lst + 1;
    if (stop_at > last_e) last_e = stop_at;
    last_e += 2;
    phase_off_i = off;
    count_i = CW'(n);
    decim_i = DW'(d);
    prev_alive = 1'b0;
    for (int e = 0; e <= last_e; e++) begin
      logic          ld;
      logic [PW-1:0] nf;
      bit            alive, ev, ed;
      ld = ($urandom_range(0, 5) == 0);
      nf = rnd_ph();
      freq_load_i = ld;
      freq_i = nf;
      stop_i = (e == stop_at);
      start_i = (e == 0) ||
                (prev_alive &&
                 $urandom_range(0, 7) == 0);
      tick();
      alive = (stop_at < 0 || e < stop_at) &&
              (n == 0 || e <= lst);
      ev = alive && (e % (d + 1) == 0);
      if (ev) ph_m = (e == 0) ? off : ph_m + freq_m;
      ed = (n > 0) && (e == lst + 1) &&
           (stop_at < 0 || stop_at > lst + 1);
      if (ld) freq_m = nf;
      chk_out("rnd", ev, alive, ed);
      prev_alive = alive;
    end
    freq_load_i = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic [PW-1:0] f, input logic [PW-1:0] o,
    input int n, input int d, input int nv,
    input logic [PW-1:0] p0, input logic [PW-1:0] p1,
    input logic [PW-1:0] p2, input logic [PW-1:0] p3,
    input int e0, input int e1,
    input int e2, input int e3,
    input int de);
    vec_t v;
    v.freq = f; v.off = o; v.n = n; v.d = d;
    v.nv = nv;
    v.ph[0] = p0; v.ph[1] = p1;
    v.ph[2] = p2; v.ph[3] = p3;
    v.ve[0] = e0; v.ve[1] = e1;
    v.ve[2] = e2; v.ve[3] = e3;
    v.done_e = de;
    return v;
  endfunction

  initial begin
    vec_t          vt [4];
    logic [PW-1:0] big;
    big = '0;
    big[46] = 1'b1;
    vt[0] = mk(47'h100, 47'h10, 4, 0, 4,
               47'h10, 47'h110, 47'h210, 47'h310,
               0, 1, 2, 3, 4);
    vt[1] = mk(47'h1, 47'h0, 3, 2, 3,
               47'h0, 47'h1, 47'h2, 47'h0,
               0, 3, 6, 0, 7);
    vt[2] = mk(big, big + 47'd5, 3, 0, 3,
               big + 47'd5, 47'd5, big + 47'd5, 47'h0,
               0, 1, 2, 0, 3);
    vt[3] = mk(47'h7, 47'h55, 1, 3, 1,
               47'h55, 47'h0, 47'h0, 47'h0,
               0, 0, 0, 0, 1);

    #3;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    #9 resetn = 1'b1;
    tick();

    foreach (vt[i]) begin
      int seen;
      int de;
      load_freq(vt[i].freq);
      phase_off_i = vt[i].off;
      count_i = CW'(vt[i].n);
      decim_i = DW'(vt[i].d);
      start_i = 1'b1;
      seen = 0;
      de = -1;
      for (int e = 0; e < 14; e++) begin
        tick();
        start_i = 1'b0;
        if (valid_o) begin
          if (seen < 4) begin
            chk("vec_phase", 64'(phase_o),
                64'(vt[i].ph[seen]));
            chk("vec_edge", 64'(e),
                64'(vt[i].ve[seen]));
          end
          seen++;
        end
        if (done_o && de < 0) de = e;
        if (e == vt[i].done_e)
          chk("vec_busy_at_done", 64'(busy_o), 64'd0);
      end
      chk("vec_nvalid", 64'(seen), 64'(vt[i].nv));
      chk("vec_done_edge", 64'(de),
          64'(vt[i].done_e));
      ph_m = vt[i].ph[vt[i].nv - 1];
    end

    // continuous run, stop sampled on edge 10
    load_freq(47'd3);
    phase_off_i = 47'd9;
    count_i = '0;
    decim_i = '0;
    start_i = 1'b1;
    for (int e = 0; e < 15; e++) begin
      tick();
      start_i = 1'b0;
      stop_i = (e == 9);
      if (e < 10) ph_m = 47'd9 + PW'(3 * e);
      chk_out("stop", e < 10, e < 10, 1'b0);
    end
    stop_i = 1'b0;

    // frequency change between samples 1 and 2
    load_freq(47'h10);
    phase_off_i = '0;
    count_i = CW'(3);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ph_m = '0;
    chk_out("fl_s0", 1'b1, 1'b1, 1'b0);
    freq_i = 47'h20;
    freq_load_i = 1'b1;
    tick();
    freq_load_i = 1'b0;
    ph_m = 47'h10;
    chk_out("fl_s1", 1'b1, 1'b1, 1'b0);
    tick();
    ph_m = 47'h30;
    chk_out("fl_s2", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("fl_done", 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("fl_idle", 1'b0, 1'b0, 1'b0);
    freq_m = 47'h20;

    // reset mid-burst, start with reset release
    load_freq(47'd5);
    phase_off_i = 47'h100;
    count_i = '0;
    decim_i = DW'(1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    ph_m = '0;
    chk_out("rst_async", 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst_hold", 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    start_i = 1'b1;
    phase_off_i = 47'h77;
    count_i = CW'(2);
    decim_i = '0;
    tick();
    start_i = 1'b0;
    ph_m = 47'h77;
    chk_out("rst_s0", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("rst_s1", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("rst_done", 1'b0, 1'b0, 1'b1);
    tick();
    freq_m = '0;

    load_freq(rnd_ph());
    for (int b = 0; b < 30; b++) begin
      int n, d, s, lst;
      n = $urandom_range(0, 5);
      d = $urandom_range(0, 3);
      lst = (n > 0) ? (n - 1) * (d + 1) : 0;
      if (n == 0)
        s = $urandom_range(1, 15);
      else if ($urandom_range(0, 2) == 0)
        s = $urandom_range(1, lst + 3);
      else
        s = -1;
      burst(rnd_ph(), n, d, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
